// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: mirror-FSM encoding,
// the NOP returned on an empty queue, and helpers used by the fetch unit.
package fetch_pkg;

  localparam logic [1:0] F_IDLE   = 2'd0;
  localparam logic [1:0] F_LOOKUP = 2'd1;
  localparam logic [1:0] F_MISS   = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Each queue entry carries {pc, instruction}.
  function automatic int entry_width(int addr_w, int data_w);
    return addr_w + data_w;
  endfunction

  // Saturating event counter step.
  function automatic logic [31:0] sat_inc(logic [31:0] value, logic en);
    return (en && value != 32'hFFFF_FFFF) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instruction} entries for decode.
// Flush empties the queue in one cycle and takes priority over push/pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign rdata  = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count alone, which keeps
  // the array a plain RAM with no reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: PC, cache-mirror FSM, redirect squash and the fetch queue.
// Optional perf counters are compiled in with `define FETCH_PERF_CNT_EN.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00000000,
  parameter int              FQ_DEPTH = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  output logic              CPU_REQ,
  output logic [ADDR_W-1:0] CPU_REQ_ADDR,
  input  logic              CPU_REQ_VALID,
  input  logic [DATA_W-1:0] CPU_REQ_DATA,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic              INST_VALID,
  input  logic              INST_READY,
  output logic [DATA_W-1:0] INST_DATA,
  output logic [ADDR_W-1:0] INST_PC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       PERF_MISS_CNT,
  output logic [31:0]       PERF_FULL_CYC,
  output logic [31:0]       PERF_SQUASH_CNT
`endif
);

  localparam int EW = entry_width(ADDR_W, DATA_W);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              kill;
  logic              run;
  logic [CW-1:0]     count;
  logic [CW-1:0]     limit;
  logic [EW-1:0]     head;
  logic              in_miss;
  logic              req;
  logic              accept;
  logic              pop;

  assign in_miss = (state == F_MISS);

  // A miss keeps one slot reserved; pre-pop count makes this conservative.
  assign limit = in_miss ? CW'(FQ_DEPTH - 1) : CW'(FQ_DEPTH);
  assign req   = run && (count < limit) && !REDIRECT;

  assign CPU_REQ      = req;
  assign CPU_REQ_ADDR = pc;

  assign accept = CPU_REQ_VALID && !kill && !REDIRECT &&
                  (in_miss || (state == F_LOOKUP && req));

  assign INST_VALID = (count != '0);
  assign pop        = INST_VALID && INST_READY;
  assign INST_PC    = INST_VALID ? head[EW-1 -: ADDR_W] : '0;
  assign INST_DATA  = INST_VALID ? head[DATA_W-1:0] : DATA_W'(NOP_INST);

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:   if (req) state_next = F_LOOKUP;
      F_LOOKUP: begin
        if (!req)               state_next = F_IDLE;
        else if (CPU_REQ_VALID) state_next = F_LOOKUP;
        else                    state_next = F_MISS;
      end
      F_MISS:   if (CPU_REQ_VALID) state_next = req ? F_LOOKUP : F_IDLE;
      default:  state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      pc    <= RESET_PC;
      state <= F_IDLE;
      kill  <= 1'b0;
      run   <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_next;
      // An outstanding miss response belongs to the old stream once redirected.
      kill  <= in_miss && !CPU_REQ_VALID && (kill || REDIRECT);
      if (REDIRECT)    pc <= REDIRECT_PC & ~ADDR_W'(3);
      else if (accept) pc <= pc + ADDR_W'(4);
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (accept),
    .pop   (pop),
    .flush (REDIRECT),
    .wdata ({pc, CPU_REQ_DATA}),
    .rdata (head),
    .count (count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic discard;

  assign discard = CPU_REQ_VALID && (kill || REDIRECT) && (in_miss || state == F_LOOKUP);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      PERF_MISS_CNT   <= '0;
      PERF_FULL_CYC   <= '0;
      PERF_SQUASH_CNT <= '0;
    end else begin
      PERF_MISS_CNT   <= sat_inc(PERF_MISS_CNT, state == F_LOOKUP && state_next == F_MISS);
      PERF_FULL_CYC   <= sat_inc(PERF_FULL_CYC, count == CW'(FQ_DEPTH));
      PERF_SQUASH_CNT <= sat_inc(PERF_SQUASH_CNT, discard);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: behavioural cache model driving the
// request port, and a scoreboard of expected {pc, instruction} queue entries.
module tb_inst_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam int          S_IDLE  = 0;
  localparam int          S_LOOKUP = 1;
  localparam int          S_MISS  = 2;
  localparam logic [31:0] NONE    = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        CPU_REQ;
  logic [31:0] CPU_REQ_ADDR;
  logic        CPU_REQ_VALID = 1'b0;
  logic [31:0] CPU_REQ_DATA = '0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        INST_VALID;
  logic        INST_READY = 1'b0;
  logic [31:0] INST_DATA;
  logic [31:0] INST_PC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] PERF_MISS_CNT;
  logic [31:0] PERF_FULL_CYC;
  logic [31:0] PERF_SQUASH_CNT;
`endif

  inst_fetch_unit dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .CPU_REQ       (CPU_REQ),
    .CPU_REQ_ADDR  (CPU_REQ_ADDR),
    .CPU_REQ_VALID (CPU_REQ_VALID),
    .CPU_REQ_DATA  (CPU_REQ_DATA),
    .REDIRECT      (REDIRECT),
    .REDIRECT_PC   (REDIRECT_PC),
    .INST_VALID    (INST_VALID),
    .INST_READY    (INST_READY),
    .INST_DATA     (INST_DATA),
    .INST_PC       (INST_PC)
`ifdef FETCH_PERF_CNT_EN
    ,
    .PERF_MISS_CNT   (PERF_MISS_CNT),
    .PERF_FULL_CYC   (PERF_FULL_CYC),
    .PERF_SQUASH_CNT (PERF_SQUASH_CNT)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  ent_t        sb[$];
  logic [31:0] mpc;
  int          c_state;
  logic        mkill;
  logic        run;
  logic [31:0] miss_addr;
  int          miss_lat;
  int          miss_left;
  int          m_miss, m_full, m_squash;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic model_reset();
    sb.delete();
    mpc = 32'h0; c_state = S_IDLE; mkill = 1'b0; run = 1'b0;
    miss_addr = NONE; miss_lat = 0; miss_left = 0;
    m_miss = 0; m_full = 0; m_squash = 0;
  endtask

  // Entered at a negedge; holds reset across n posedges, checks outputs in reset.
  task automatic do_reset(input int n);
    ARESETn = 1'b0; REDIRECT = 1'b0; CPU_REQ_VALID = 1'b0; CPU_REQ_DATA = '0;
    repeat (n) begin
      @(posedge ACLK); #1;
      check("rst_cpu_req", CPU_REQ, 1'b0);
      check("rst_inst_valid", INST_VALID, 1'b0);
      check("rst_inst_data", INST_DATA, NOP);
      check("rst_inst_pc", INST_PC, 32'h0);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    model_reset();
  endtask

  // One clock cycle: entered and left at a negedge.
  task automatic cycle();
    logic        valid;
    logic [31:0] addr;
    int          pre_cnt;
    logic        exp_req;
    logic        accept;
    int          nxt;
    addr  = CPU_REQ_ADDR;
    valid = 1'b0;
    if (c_state == S_LOOKUP)    valid = (addr != miss_addr);
    else if (c_state == S_MISS) valid = (miss_left == 0);
    CPU_REQ_VALID = valid;
    CPU_REQ_DATA  = valid ? inst_of(addr) : 32'h0;
    #1;
    pre_cnt = sb.size();
    exp_req = run && (pre_cnt < DEPTH - ((c_state == S_MISS) ? 1 : 0)) && !REDIRECT;
    check("cpu_req", CPU_REQ, exp_req);
    if (exp_req || c_state == S_MISS) check("req_addr", CPU_REQ_ADDR, mpc);
    check("inst_valid", INST_VALID, pre_cnt != 0);
    if (pre_cnt != 0) begin
      check("inst_pc", INST_PC, sb[0].pc);
      check("inst_data", INST_DATA, sb[0].data);
      if (INST_READY) void'(sb.pop_front());
    end else begin
      check("empty_pc", INST_PC, 32'h0);
      check("empty_data", INST_DATA, NOP);
    end
    accept = valid && !mkill && !REDIRECT &&
             (c_state == S_MISS || (c_state == S_LOOKUP && exp_req));
    if (valid && c_state != S_IDLE && (mkill || REDIRECT)) m_squash++;
    if (pre_cnt == DEPTH) m_full++;
    if (REDIRECT) begin
      sb.delete();
      mpc = REDIRECT_PC & ~32'h3;
    end else if (accept) begin
      sb.push_back('{pc: mpc, data: inst_of(mpc)});
      mpc = mpc + 32'd4;
    end
    mkill = (c_state == S_MISS) && !valid && (mkill || REDIRECT);
    nxt = c_state;
    case (c_state)
      S_IDLE:   if (exp_req) nxt = S_LOOKUP;
      S_LOOKUP: nxt = !exp_req ? S_IDLE : (valid ? S_LOOKUP : S_MISS);
      default:  if (valid) nxt = exp_req ? S_LOOKUP : S_IDLE;
    endcase
    if (c_state == S_LOOKUP && nxt == S_MISS) begin
      m_miss++;
      miss_left = miss_lat - 1;
      miss_addr = NONE;
    end else if (c_state == S_MISS && !valid) begin
      miss_left--;
    end
    c_state = nxt;
    @(posedge ACLK);
    run = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_state(input int st, input int cap);
    int k;
    k = 0;
    while (c_state != st && k < cap) begin cycle(); k++; end
    check("wait_state", (c_state == st), 1'b1);
  endtask

  task automatic wait_inst(input int cap);
    int k;
    k = 0;
    while (!INST_VALID && k < cap) begin cycle(); k++; end
    check("wait_inst", INST_VALID, 1'b1);
  endtask

  task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
    check("perf_miss", PERF_MISS_CNT, m_miss);
    check("perf_full", PERF_FULL_CYC, m_full);
    check("perf_squash", PERF_SQUASH_CNT, m_squash);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // 1: every lookup hits, decode always ready.
    do_reset(3);
    INST_READY = 1'b1;
    run_cycles(12);
    check_perf();

    // 2: first lookup misses; response arrives 20 cycles later.
    do_reset(2);
    miss_addr = 32'h0; miss_lat = 20;
    wait_inst(40);
    check("miss_first_pc", INST_PC, 32'h0);
    run_cycles(6);
    check_perf();

    // 3: decode stalled until the queue fills, then drains in order.
    do_reset(2);
    INST_READY = 1'b0;
    run_cycles(10);
    check("full_req_low", CPU_REQ, 1'b0);
    check("full_head_pc", INST_PC, 32'h0);
    INST_READY = 1'b1;
    run_cycles(14);

    // 4: redirect to 0x40 (which misses), then redirect to 0x103 mid-miss.
    wait_state(S_LOOKUP, 10);
    miss_addr = 32'h40; miss_lat = 10;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
    cycle();
    REDIRECT = 1'b0;
    wait_state(S_MISS, 10);
    run_cycles(2);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
    cycle();
    REDIRECT = 1'b0;
    check("squash_empty", INST_VALID, 1'b0);
    check("squash_addr", CPU_REQ_ADDR, 32'h100);
    wait_inst(40);
    check("squash_next_pc", INST_PC, 32'h100);
    run_cycles(4);
    check_perf();

    // 5: redirect coinciding with the hit at 0x8, two entries queued.
    do_reset(2);
    INST_READY = 1'b0;
    begin
      int k;
      k = 0;
      while (!(c_state == S_LOOKUP && mpc == 32'h8) && k < 10) begin cycle(); k++; end
      check("reach_hit8", (c_state == S_LOOKUP && mpc == 32'h8), 1'b1);
    end
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    cycle();
    REDIRECT = 1'b0;
    check("hit_redir_empty", INST_VALID, 1'b0);
    check("hit_redir_addr", CPU_REQ_ADDR, 32'h200);
    INST_READY = 1'b1;
    run_cycles(8);
    check_perf();

    // 6: reset pulse mid-miss with three entries queued.
    do_reset(2);
    INST_READY = 1'b0;
    miss_addr = 32'hC; miss_lat = 30;
    wait_state(S_MISS, 10);
    run_cycles(3);
    do_reset(1);
    INST_READY = 1'b1;
    wait_inst(10);
    check("restart_pc", INST_PC, 32'h0);
    run_cycles(8);
    check_perf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
